start_window_ctrl: RTL and testbench

Controller that issues a one-cycle `start` pulse to a downstream datapath on request and requires a `done` response within a bounded window of clock cycles. Default window is 20 cycles. On a missed window it re-fires `start` up to a retry limit, then reports failure. It sits between a requester (sequencer or CPU-side register) and the datapath whose `start` is checked by the team's start-within-window assertions, so that property holds by construction.

---
 rtl/start_ctrl_pkg.sv | 14 +
 rtl/window_counter.sv | 27 ++
 rtl/start_window_ctrl.sv | 133 +++++++++++++
 tb/tb_start_window_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/start_ctrl_pkg.sv
// Shared types and defaults for the start-within-window controller.
package start_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } start_ctrl_state_e;

  localparam int START_TIMEOUT_DEF   = 20;
  localparam int START_MAX_RETRY_DEF = 3;
  localparam int START_STATS_W       = 16;

endpackage

// File: rtl/window_counter.sv
// Response-window counter: loads 1 on a start pulse, counts up and holds at TIMEOUT.
module window_counter #(
  parameter int TIMEOUT = 20,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          expired
);

  assign expired = (count == CW'(TIMEOUT));

  // Holding at TIMEOUT keeps the counter from wrapping if the FSM lingers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/start_window_ctrl.sv
// Issues start pulses, waits a bounded window for done, retries, then reports ok/fail.
// Optional statistics outputs are enabled by defining START_CTRL_STATS_EN.
module start_window_ctrl
  import start_ctrl_pkg::*;
#(
  parameter int TIMEOUT   = START_TIMEOUT_DEF,
  parameter int MAX_RETRY = START_MAX_RETRY_DEF,
  parameter int CW        = $clog2(TIMEOUT + 1),
  parameter int RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  output logic                     start,
  input  logic                     done,
  output logic                     busy,
  output logic                     ok,
  output logic                     fail,
  output logic [RW-1:0]            retry_cnt
`ifdef START_CTRL_STATS_EN
  ,
  output logic [START_STATS_W-1:0] fail_total,
  output logic [START_STATS_W-1:0] retry_total
`endif
);

  start_ctrl_state_e state;
  start_ctrl_state_e state_next;

  logic          win_load;
  logic          win_en;
  logic          expired;
  logic [CW-1:0] win_count;
  logic          in_window;
  logic          ok_set;
  logic          fail_set;
  logic          retry_fire;
  logic          retry_clear;

  window_counter #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .load    (win_load),
    .enable  (win_en),
    .count   (win_count),
    .expired (expired)
  );

  // ok/fail are registered so they land in the cycle IDLE is re-entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ok    <= 1'b0;
      fail  <= 1'b0;
    end else begin
      state <= state_next;
      ok    <= ok_set;
      fail  <= fail_set;
    end
  end

  assign in_window = (state == WAIT) && (win_count != '0);

  always_comb begin
    state_next  = state;
    ok_set      = 1'b0;
    fail_set    = 1'b0;
    retry_fire  = 1'b0;
    retry_clear = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_next  = FIRE;
          retry_clear = 1'b1;
        end
      end
      FIRE: state_next = WAIT;
      WAIT: begin
        // A done on the last window cycle beats the timeout.
        if (in_window && done) begin
          state_next = IDLE;
          ok_set     = 1'b1;
        end else if (expired) begin
          if (retry_cnt < RW'(MAX_RETRY)) begin
            state_next = FIRE;
            retry_fire = 1'b1;
          end else begin
            state_next = IDLE;
            fail_set   = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start    = (state == FIRE);
    busy     = (state != IDLE);
    win_load = (state == FIRE);
    win_en   = (state == WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (retry_clear) begin
      retry_cnt <= '0;
    end else if (retry_fire) begin
      retry_cnt <= retry_cnt + RW'(1);
    end
  end

`ifdef START_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_total  <= '0;
      retry_total <= '0;
    end else begin
      if (fail_set && (fail_total != '1)) begin
        fail_total <= fail_total + START_STATS_W'(1);
      end
      if (retry_fire && (retry_total != '1)) begin
        retry_total <= retry_total + START_STATS_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_start_window_ctrl.sv
// Self-checking bench: two controllers (MAX_RETRY=2 and 0) against a cycle-age reference model.
module tb_start_window_ctrl;

  localparam int TO  = 20;
  localparam int MR0 = 2;
  localparam int MR1 = 0;

  logic       clk;
  logic       rst;
  logic       req;
  logic       done;
  logic       start0, busy0, ok0, fail0;
  logic [1:0] retry0;
  logic       start1, busy1, ok1, fail1;
  logic [0:0] retry1;
`ifdef START_CTRL_STATS_EN
  logic [15:0] ftot0, rtot0, ftot1, rtot1;
`endif

  int total;
  int bad;
  int cyc;
  int start_count;
  int last_start;
  int first_ok;
  int fail_cyc;
  int fail1_cyc;

  bit m_active[2];
  int m_age[2];
  int m_retry[2];
  bit m_start[2];
  bit m_ok[2];
  bit m_fail[2];
  int m_ftot[2];
  int m_rtot[2];

  start_window_ctrl #(.TIMEOUT(TO), .MAX_RETRY(MR0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .start(start0), .done(done),
    .busy(busy0), .ok(ok0), .fail(fail0), .retry_cnt(retry0)
`ifdef START_CTRL_STATS_EN
    , .fail_total(ftot0), .retry_total(rtot0)
`endif
  );

  start_window_ctrl #(.TIMEOUT(TO), .MAX_RETRY(MR1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .start(start1), .done(done),
    .busy(busy1), .ok(ok1), .fail(fail1), .retry_cnt(retry1)
`ifdef START_CTRL_STATS_EN
    , .fail_total(ftot1), .retry_total(rtot1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, act, exp);
    end
  endtask

  // Model tracks cycles since the last start; window is ages 1..TO.
  task automatic modelStep(input int i, input bit r, input bit q, input bit d);
    int mr;
    mr = (i == 0) ? MR0 : MR1;
    m_start[i] = 0;
    m_ok[i]    = 0;
    m_fail[i]  = 0;
    if (r) begin
      m_active[i] = 0; m_age[i] = 0; m_retry[i] = 0; m_ftot[i] = 0; m_rtot[i] = 0;
    end else if (!m_active[i]) begin
      if (q) begin
        m_active[i] = 1; m_age[i] = 0; m_retry[i] = 0; m_start[i] = 1;
      end
    end else if (m_age[i] >= 1 && d) begin
      m_active[i] = 0; m_ok[i] = 1;
    end else if (m_age[i] == TO) begin
      if (m_retry[i] < mr) begin
        m_retry[i]++; m_age[i] = 0; m_start[i] = 1;
        if (m_rtot[i] < 65535) m_rtot[i]++;
      end else begin
        m_active[i] = 0; m_fail[i] = 1;
        if (m_ftot[i] < 65535) m_ftot[i]++;
      end
    end else begin
      m_age[i]++;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit q, input bit d);
    rst = r; req = q; done = d;
    @(posedge clk);
    modelStep(0, r, q, d);
    modelStep(1, r, q, d);
    #1;
    cyc++;
    checkOutput("start0", int'(start0), int'(m_start[0]));
    checkOutput("busy0",  int'(busy0),  int'(m_active[0]));
    checkOutput("ok0",    int'(ok0),    int'(m_ok[0]));
    checkOutput("fail0",  int'(fail0),  int'(m_fail[0]));
    checkOutput("retry0", int'(retry0), m_retry[0]);
    checkOutput("start1", int'(start1), int'(m_start[1]));
    checkOutput("busy1",  int'(busy1),  int'(m_active[1]));
    checkOutput("ok1",    int'(ok1),    int'(m_ok[1]));
    checkOutput("fail1",  int'(fail1),  int'(m_fail[1]));
    checkOutput("retry1", int'(retry1), m_retry[1]);
`ifdef START_CTRL_STATS_EN
    checkOutput("fail_total0",  int'(ftot0), m_ftot[0]);
    checkOutput("retry_total0", int'(rtot0), m_rtot[0]);
    checkOutput("fail_total1",  int'(ftot1), m_ftot[1]);
    checkOutput("retry_total1", int'(rtot1), m_rtot[1]);
`endif
    if (start0) begin start_count++; last_start = cyc; end
    if (ok0 && first_ok < 0) first_ok = cyc;
    if (fail0) fail_cyc = cyc;
    if (fail1) fail1_cyc = cyc;
  endtask

  task automatic beginScenario();
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    cyc = 0; start_count = 0; last_start = -1;
    first_ok = -1; fail_cyc = -1; fail1_cyc = -1;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst = 1; req = 0; done = 0;
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_age[i] = 0; m_retry[i] = 0;
      m_start[i] = 0; m_ok[i] = 0; m_fail[i] = 0; m_ftot[i] = 0; m_rtot[i] = 0;
    end

    beginScenario();
    checkOutput("reset_busy", int'(busy0), 0);
    checkOutput("reset_retry", int'(retry0), 0);

    // Prompt response
    for (int c = 0; c < 10; c++) applyStimulus(0, c == 0, c == 5);
    checkOutput("prompt_ok_cycle", first_ok, 6);
    checkOutput("prompt_starts", start_count, 1);

    // Done on the final window cycle
    beginScenario();
    for (int c = 0; c < 25; c++) applyStimulus(0, c == 0, c == 21);
    checkOutput("last_ok_cycle", first_ok, 22);
    checkOutput("last_starts", start_count, 1);

    // Done one cycle too late
    beginScenario();
    for (int c = 0; c < 25; c++) applyStimulus(0, c == 0, c == 22);
    checkOutput("late_starts", start_count, 2);
    checkOutput("late_second_start", last_start, 22);
    checkOutput("late_retry", int'(retry0), 1);

    // Total failure
    beginScenario();
    for (int c = 0; c < 70; c++) applyStimulus(0, c == 0, 1'b0);
    checkOutput("fail_starts", start_count, 3);
    checkOutput("fail_last_start", last_start, 43);
    checkOutput("fail_cycle", fail_cyc, 64);
    checkOutput("fail_retry", int'(retry0), 2);
    checkOutput("noretry_fail_cycle", fail1_cyc, 22);
`ifdef START_CTRL_STATS_EN
    checkOutput("fail_total_const", int'(ftot0), 1);
    checkOutput("retry_total_const", int'(rtot0), 2);
`endif

    // Ignored done in FIRE cycle and req while busy
    beginScenario();
    for (int c = 0; c < 70; c++) applyStimulus(0, c == 0 || c == 3 || c == 10, c == 1);
    checkOutput("ignored_starts", start_count, 3);
    checkOutput("ignored_fail_cycle", fail_cyc, 64);

    // Reset mid-window
    beginScenario();
    for (int c = 0; c < 16; c++) applyStimulus(c == 10, c == 0, c == 12);
    checkOutput("rst_no_ok", first_ok, -1);
    checkOutput("rst_starts", start_count, 1);

    // Back-to-back with req held high
    beginScenario();
    for (int c = 0; c < 30; c++) applyStimulus(0, 1'b1, m_active[0] && m_age[0] == 3);
    checkOutput("b2b_starts", start_count, 6);
    checkOutput("b2b_last_start", last_start, 26);

    // Randomized traffic
    beginScenario();
    for (int blk = 0; blk < 6; blk++) begin
      int dprob;
      dprob = (blk % 2 == 0) ? 12 : 2;
      for (int c = 0; c < 500; c++) begin
        applyStimulus($urandom_range(0, 199) == 0,
                      $urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < dprob);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
